memory_stage: RTL and testbench
===============================

# memory_stage

Consumes the execute stage's results and performs the MEM step of the MIPS pipeline. It registers ALU_result, read_data_2, write_register_index, add_result and Zero, and resolves the branch as PCSrc. Loads and stores run against a variable-latency data memory through a req/ack handshake, with back-pressure to execute. The block then delivers one registered MEM/WB record per instruction to the write-back stage.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath and address width
- ACK_TIMEOUT, 16, maximum cycles waiting for mem_ack before abort (range 1..255)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute offers an instruction this cycle
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready
- RegWrite, MemtoReg, MemRead, MemWrite, Branch  in  1 each  control bits from execute
- ALU_result  in  DATA_WIDTH  result or memory address
- read_data_2  in  DATA_WIDTH  store data
- add_result  in  DATA_WIDTH  branch target
- Zero  in  1  ALU zero flag
- write_register_index  in  5  destination register
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  DATA_WIDTH  word address
- mem_wdata  out  DATA_WIDTH  store data
- mem_ack  in  1  memory completion, single-cycle pulse
- mem_rdata  in  DATA_WIDTH  load data, valid with mem_ack
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_RegWrite, wb_MemtoReg  out  1 each  forwarded controls, gated by faults
- wb_read_data  out  DATA_WIDTH  load data
- wb_ALU_result  out  DATA_WIDTH  registered ALU result
- wb_write_register_index  out  5  destination register
- PCSrc  out  1  Branch && Zero, one-cycle pulse
- branch_target  out  DATA_WIDTH  registered add_result
- misaligned  out  1  pulse with wb_valid when the access address has bits [1:0] != 0
- bus_error  out  1  pulse with wb_valid when the access timed out

## Operation
- FSM states: IDLE, ACCESS, RETIRE.
- IDLE:
  - in_ready = 1.
  - On transfer, latch all inputs.
  - An instruction with neither MemRead nor MemWrite goes to RETIRE.
  - A memory instruction with ALU_result[1:0] != 0 goes to RETIRE with misaligned set; mem_req is never raised.
  - An aligned memory instruction goes to ACCESS.
- MemWrite has priority over MemRead if both are set; the instruction is treated as a store.
- ACCESS:
  - in_ready = 0; mem_req = 1.
  - mem_addr, mem_we and mem_wdata are stable for the whole request.
  - The timeout counter loads 0 on entry and increments each cycle.
  - On mem_ack: capture mem_rdata (loads only) and go to RETIRE.
  - When the counter reaches ACK_TIMEOUT-1 without an ack: set bus_error and go to RETIRE.
- RETIRE:
  - Output registers drive wb_valid = 1 for exactly one cycle; PCSrc pulses in the same cycle.
  - in_ready = 1, so a new transfer may be accepted in this cycle (back-to-back). The next state is chosen as in IDLE; with no transfer, the next state is IDLE.
- Fault gating: when misaligned or bus_error is set, wb_RegWrite = 0 and PCSrc = 0.
- A store retires with wb_RegWrite forced to 0.
- wb_read_data holds its last value for non-load retirements.
- A mem_ack outside ACCESS is ignored.
- A mem_ack arriving in the same cycle as the timeout wins: no bus_error.

## Timing
- Reset: all outputs 0, state IDLE, in_ready goes to 1 after reset release. An asynchronous reset during ACCESS drops mem_req immediately, and no retirement occurs.
- Non-memory latency: transfer at edge N gives wb_valid high in cycle N+1.
- Memory latency: mem_req rises in the cycle after transfer. mem_ack in cycle A gives wb_valid in cycle A+1.
- Throughput: one non-memory instruction per cycle.
- Worst-case timeout retirement: ACK_TIMEOUT+1 cycles after the transfer edge.
- The counter is 8 bits and does not wrap within the legal parameter range.

## Structure
- Shared package mips_pkg holds:
  - the state enum (IDLE/ACCESS/RETIRE)
  - the DATA_WIDTH default
  - REG_INDEX_WIDTH = 5
  - the MEM/WB record field widths shared with the write-back stage
- One sub-module, ack_timer: load/increment/expire counter parameterised by ACK_TIMEOUT.

## Test plan
- Reset: hold reset_n = 0 mid-stream, then release → all outputs 0 and in_ready = 1 in the first cycle after release.
- R-type: transfer ALU_result = 555, write_register_index = 20, RegWrite = 1 → next cycle wb_valid = 1, wb_ALU_result = 555, wb_write_register_index = 20, mem_req never asserted. Repeat back-to-back for 4 cycles → 4 consecutive wb_valid pulses.
- Load: MemRead = 1, ALU_result = 0x100; ack after 3 cycles with mem_rdata = 0xDEADBEEF → mem_addr = 0x100 and mem_we = 0 throughout. in_ready = 0 during ACCESS. wb_read_data = 0xDEADBEEF the cycle after ack.
- Store then branch:
  - Store with read_data_2 = 333 to address 0x20 → mem_we = 1, mem_wdata = 333, retires with wb_RegWrite = 0.
  - Branch = 1, Zero = 1, add_result = 111 → PCSrc pulse with branch_target = 111.
  - Branch = 1, Zero = 0 → no pulse.
- Misaligned load at address 0x102 → no mem_req, wb_valid with misaligned = 1 and wb_RegWrite = 0.
- Timeout: ACK_TIMEOUT = 4, mem_ack never asserted → mem_req high for 4 cycles, then wb_valid with bus_error = 1. A second run with the ack on the final counter cycle → no bus_error.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages: FSM states, datapath
// defaults and the field widths of the MEM/WB record.
package mips_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int REG_INDEX_WIDTH = 5;
  localparam int TIMER_WIDTH     = 8;

  // MEM/WB record layout shared with the write-back stage.
  localparam int WB_CTRL_WIDTH   = 2;  // RegWrite, MemtoReg
  localparam int WB_FLAG_WIDTH   = 2;  // misaligned, bus_error
  localparam int WB_RECORD_WIDTH = WB_CTRL_WIDTH + WB_FLAG_WIDTH + REG_INDEX_WIDTH
                                 + 2 * DATA_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RETIRE = 2'd2
  } state_t;

  // Word accesses must have the two low address bits clear.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory bus bundle. The stage is the master: it raises mem_req with
// stable mem_we/mem_addr/mem_wdata and holds it until the memory answers with
// a single-cycle mem_ack (mem_rdata valid in that cycle) or the stage gives up.
interface memory_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/memory_stage_ack_timer.sv
// Acknowledge watchdog: cleared when a request starts, counts request cycles,
// and flags the last cycle the stage is willing to wait.
module ack_timer
  import mips_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic inc,
  output logic expired
);

  localparam logic [TIMER_WIDTH-1:0] LAST_COUNT = TIMER_WIDTH'(ACK_TIMEOUT - 1);

  logic [TIMER_WIDTH-1:0] count;

  // Count request cycles; load restarts from zero for a new request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  count <= '0;
    else if (load) count <= '0;
    else if (inc)  count <= count + 1'b1;
  end

  assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/memory_stage.sv
// MEM step of the MIPS pipeline: latches one instruction from execute, runs
// its load/store against a variable-latency memory, resolves the branch and
// presents one registered MEM/WB record per instruction.
//
// Handshake: execute -> stage transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is low only while a memory access is open,
// so RETIRE can accept the next instruction back-to-back.
module memory_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       RegWrite,
  input  logic                       MemtoReg,
  input  logic                       MemRead,
  input  logic                       MemWrite,
  input  logic                       Branch,
  input  logic [DATA_WIDTH-1:0]      ALU_result,
  input  logic [DATA_WIDTH-1:0]      read_data_2,
  input  logic [DATA_WIDTH-1:0]      add_result,
  input  logic                       Zero,
  input  logic [REG_INDEX_WIDTH-1:0] write_register_index,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [DATA_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic                       mem_ack,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       wb_valid,
  output logic                       wb_RegWrite,
  output logic                       wb_MemtoReg,
  output logic [DATA_WIDTH-1:0]      wb_read_data,
  output logic [DATA_WIDTH-1:0]      wb_ALU_result,
  output logic [REG_INDEX_WIDTH-1:0] wb_write_register_index,
  output logic                       PCSrc,
  output logic [DATA_WIDTH-1:0]      branch_target,
  output logic                       misaligned,
  output logic                       bus_error
);

  state_t state, state_next;

  logic ready_en;
  logic accept, mem_in, mis_in;
  logic retire_direct, retire_mem, retire_err;
  logic timer_load, timer_inc, timer_expired;

  // Instruction held for the duration of a memory access.
  logic                       lat_reg_write, lat_memto_reg;
  logic                       lat_is_store, lat_is_load;
  logic                       lat_branch, lat_zero;
  logic [DATA_WIDTH-1:0]      lat_alu, lat_wdata, lat_add;
  logic [REG_INDEX_WIDTH-1:0] lat_wr_idx;

  assign in_ready = ready_en && (state != ACCESS);
  assign accept   = in_valid && in_ready;
  assign mem_in   = MemRead || MemWrite;
  assign mis_in   = mem_in && is_misaligned(ALU_result[1:0]);

  assign mem_req   = (state == ACCESS);
  assign mem_we    = mem_req && lat_is_store;
  assign mem_addr  = lat_alu;
  assign mem_wdata = lat_wdata;

  ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (timer_load),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  // in_ready stays low through reset and comes up on the first edge after it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and retirement source; an ack in the timeout cycle wins.
  always_comb begin
    state_next    = (state == RETIRE) ? IDLE : state;
    retire_direct = 1'b0;
    retire_mem    = 1'b0;
    retire_err    = 1'b0;
    timer_load    = 1'b0;
    timer_inc     = 1'b0;
    case (state)
      IDLE, RETIRE: begin
        if (accept) begin
          if (mem_in && !mis_in) begin
            state_next = ACCESS;
            timer_load = 1'b1;
          end else begin
            state_next    = RETIRE;
            retire_direct = 1'b1;
          end
        end
      end
      ACCESS: begin
        timer_inc = 1'b1;
        if (mem_ack) begin
          state_next = RETIRE;
          retire_mem = 1'b1;
        end else if (timer_expired) begin
          state_next = RETIRE;
          retire_err = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the accepted instruction; MemWrite outranks MemRead.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_reg_write <= 1'b0;
      lat_memto_reg <= 1'b0;
      lat_is_store  <= 1'b0;
      lat_is_load   <= 1'b0;
      lat_branch    <= 1'b0;
      lat_zero      <= 1'b0;
      lat_alu       <= '0;
      lat_wdata     <= '0;
      lat_add       <= '0;
      lat_wr_idx    <= '0;
    end else if (accept) begin
      lat_reg_write <= RegWrite;
      lat_memto_reg <= MemtoReg;
      lat_is_store  <= MemWrite;
      lat_is_load   <= MemRead && !MemWrite;
      lat_branch    <= Branch;
      lat_zero      <= Zero;
      lat_alu       <= ALU_result;
      lat_wdata     <= read_data_2;
      lat_add       <= add_result;
      lat_wr_idx    <= write_register_index;
    end
  end

  // MEM/WB record: pulses last one cycle, data fields hold between retirements.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid                <= 1'b0;
      wb_RegWrite             <= 1'b0;
      wb_MemtoReg             <= 1'b0;
      wb_read_data            <= '0;
      wb_ALU_result           <= '0;
      wb_write_register_index <= '0;
      PCSrc                   <= 1'b0;
      branch_target           <= '0;
      misaligned              <= 1'b0;
      bus_error               <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      PCSrc      <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      if (retire_direct) begin
        // Non-memory or misaligned: retires straight from the execute inputs.
        wb_valid                <= 1'b1;
        wb_RegWrite             <= RegWrite && !MemWrite && !mis_in;
        wb_MemtoReg             <= MemtoReg && !mis_in;
        wb_ALU_result           <= ALU_result;
        wb_write_register_index <= write_register_index;
        PCSrc                   <= Branch && Zero && !mis_in;
        branch_target           <= add_result;
        misaligned              <= mis_in;
      end else if (retire_mem || retire_err) begin
        wb_valid                <= 1'b1;
        wb_RegWrite             <= lat_reg_write && !lat_is_store && !retire_err;
        wb_MemtoReg             <= lat_memto_reg && !retire_err;
        wb_ALU_result           <= lat_alu;
        wb_write_register_index <= lat_wr_idx;
        PCSrc                   <= lat_branch && lat_zero && !retire_err;
        branch_target           <= lat_add;
        bus_error               <= retire_err;
        if (retire_mem && lat_is_load) wb_read_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: drives instructions from execute, plays the data
// memory with chosen ack delays, and compares every retirement against a
// record predicted from the stage's rules.
module tb_memory_stage;
  import mips_pkg::*;

  localparam int DW    = 32;
  localparam int T     = 4;
  localparam int REC_W = 5 + 5 + 4 * DW;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic          in_valid, in_ready;
  logic          RegWrite, MemtoReg, MemRead, MemWrite, Branch, Zero;
  logic [DW-1:0] ALU_result, read_data_2, add_result;
  logic [4:0]    write_register_index;
  logic          wb_valid, wb_RegWrite, wb_MemtoReg, PCSrc, misaligned, bus_error;
  logic [DW-1:0] wb_read_data, wb_ALU_result, branch_target;
  logic [4:0]    wb_write_register_index;

  memory_stage_if #(.DATA_WIDTH(DW)) bus ();

  memory_stage #(.DATA_WIDTH(DW), .ACK_TIMEOUT(T)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch),
    .ALU_result(ALU_result), .read_data_2(read_data_2), .add_result(add_result),
    .Zero(Zero), .write_register_index(write_register_index),
    .mem_req(bus.mem_req), .mem_we(bus.mem_we), .mem_addr(bus.mem_addr),
    .mem_wdata(bus.mem_wdata), .mem_ack(bus.mem_ack), .mem_rdata(bus.mem_rdata),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_read_data(wb_read_data), .wb_ALU_result(wb_ALU_result),
    .wb_write_register_index(wb_write_register_index),
    .PCSrc(PCSrc), .branch_target(branch_target),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  int checks = 0;
  int errors = 0;

  logic [REC_W-1:0] exp_q[$];
  logic [DW-1:0]    mdl_rd;

  // Observations from the last issued instruction.
  int               obs_lat, obs_req;
  logic             obs_timeout, obs_bus_bad, obs_ready_bad;
  logic             obs_we;
  logic [DW-1:0]    obs_addr, obs_wdata;
  logic [REC_W-1:0] obs_rec;

  // Reference model: what retires, when, and how long mem_req is held.
  task automatic model(input logic rw, m2r, mr, mw, br, z,
                       input logic [DW-1:0] alu, add, input logic [4:0] idx,
                       input int ack_k, input logic [DW-1:0] rdata,
                       output logic [REC_W-1:0] rec, output int lat, output int req);
    logic mem, mis, acked, err, fault;
    mem   = mr | mw;
    mis   = mem && (alu % 4 != 0);
    acked = mem && !mis && ack_k >= 0 && ack_k < T;
    err   = mem && !mis && !acked;
    fault = mis | err;
    if (!mem || mis) begin lat = 1;     req = 0;       end
    else if (err)    begin lat = T + 1; req = T;       end
    else             begin lat = ack_k + 2; req = ack_k + 1; end
    if (acked && !mw) mdl_rd = rdata;
    rec = {rw && !mw && !fault, m2r && !fault, br && z && !fault, mis, err,
           idx, alu, mdl_rd, add};
  endtask

  // Driver: transfers one instruction, acts as memory, and records the retirement.
  task automatic issue(input logic rw, m2r, mr, mw, br, z,
                       input logic [DW-1:0] alu, rd2, add, input logic [4:0] idx,
                       input int ack_k, input logic [DW-1:0] rdata);
    RegWrite = rw; MemtoReg = m2r; MemRead = mr; MemWrite = mw;
    Branch = br; Zero = z; ALU_result = alu; read_data_2 = rd2;
    add_result = add; write_register_index = idx; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    ALU_result = $urandom; read_data_2 = $urandom; add_result = $urandom;
    write_register_index = 5'($urandom);
    obs_lat = 0; obs_req = 0; obs_timeout = 1'b1;
    obs_bus_bad = 1'b0; obs_ready_bad = 1'b0;
    for (int c = 1; c <= T + 6; c++) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      if (wb_valid) begin
        obs_lat = c; obs_timeout = 1'b0;
        obs_rec = {wb_RegWrite, wb_MemtoReg, PCSrc, misaligned, bus_error,
                   wb_write_register_index, wb_ALU_result, wb_read_data, branch_target};
        break;
      end
      if (bus.mem_req) begin
        if (obs_req == 0) begin
          obs_addr = bus.mem_addr; obs_we = bus.mem_we; obs_wdata = bus.mem_wdata;
        end else if (bus.mem_addr !== obs_addr || bus.mem_we !== obs_we ||
                     bus.mem_wdata !== obs_wdata) begin
          obs_bus_bad = 1'b1;
        end
        if (in_ready) obs_ready_bad = 1'b1;
        if (obs_req == ack_k) begin bus.mem_ack = 1'b1; bus.mem_rdata = rdata; end
        obs_req++;
      end
      @(posedge clock); #1;
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    logic [REC_W-1:0] rec; int lat, req;
    model(1, 0, 0, 0, 0, 0, 32'h44, 32'h88, 5'd7, -1, 0, rec, lat, req);
    issue(1, 0, 0, 0, 0, 0, 32'h44, 0, 32'h88, 5'd7, -1, 0);
    @(posedge clock); #1;
    MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; ALU_result = 32'h40;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; MemRead = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL reset_pre_req got %b exp 1", bus.mem_req);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_async got req=%b rdy=%b exp 0 0", bus.mem_req, in_ready);
    end
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    mdl_rd = '0;
    checks++;
    if ({wb_valid, wb_RegWrite, wb_MemtoReg, wb_read_data, wb_ALU_result,
         wb_write_register_index, PCSrc, branch_target, misaligned, bus_error,
         bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got alu=%h idx=%0d addr=%h exp all zero",
                         wb_ALU_result, wb_write_register_index, bus.mem_addr);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wb_valid !== 1'b0) begin
        errors++; $display("FAIL reset_no_retire got wb_valid=%b exp 0", wb_valid);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_rtype;
    logic [REC_W-1:0] rec; int lat, req;
    model(1, 0, 0, 0, 0, 0, 555, 32'h9, 5'd20, -1, 0, rec, lat, req);
    issue(1, 0, 0, 0, 0, 0, 555, 32'h3, 32'h9, 5'd20, -1, 0);
    checks++;
    if (obs_timeout || obs_lat !== lat || obs_req !== 0) begin
      errors++; $display("FAIL rtype_timing got lat=%0d req=%0d exp lat=%0d req=0", obs_lat, obs_req, lat);
    end
    checks++;
    if (wb_ALU_result !== 555 || wb_write_register_index !== 5'd20 || wb_RegWrite !== 1'b1) begin
      errors++; $display("FAIL rtype_fields got alu=%0d idx=%0d rw=%b exp 555 20 1",
                         wb_ALU_result, wb_write_register_index, wb_RegWrite);
    end
    checks++;
    if (obs_rec !== rec) begin
      errors++; $display("FAIL rtype_rec got %h exp %h", obs_rec, rec);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] vals [4];
    for (int i = 0; i < 4; i++) vals[i] = 1000 + 17 * i;
    RegWrite = 1'b1; MemtoReg = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Branch = 1'b0; Zero = 1'b0; write_register_index = 5'd3;
    ALU_result = vals[0]; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (i < 3) ALU_result = vals[i + 1];
      else       in_valid = 1'b0;
      checks++;
      if (wb_valid !== 1'b1 || wb_ALU_result !== vals[i] || in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b[%0d] got v=%b alu=%0d rdy=%b exp 1 %0d 1",
                           i, wb_valid, wb_ALU_result, in_ready, vals[i]);
      end
    end
    @(posedge clock); #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end got wb_valid=%b exp 0", wb_valid);
    end
  endtask

  task automatic test_load;
    logic [REC_W-1:0] rec; int lat, req;
    model(1, 1, 1, 0, 0, 0, 32'h100, 32'h0, 5'd9, 2, 32'hDEADBEEF, rec, lat, req);
    issue(1, 1, 1, 0, 0, 0, 32'h100, 32'h5, 32'h0, 5'd9, 2, 32'hDEADBEEF);
    checks++;
    if (obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_bus_bad) begin
      errors++; $display("FAIL load_bus got addr=%h we=%b unstable=%b exp 100 0 0",
                         obs_addr, obs_we, obs_bus_bad);
    end
    checks++;
    if (obs_ready_bad) begin
      errors++; $display("FAIL load_ready got in_ready=1 during access exp 0");
    end
    checks++;
    if (obs_timeout || obs_lat !== lat || obs_req !== req) begin
      errors++; $display("FAIL load_timing got lat=%0d req=%0d exp %0d %0d", obs_lat, obs_req, lat, req);
    end
    checks++;
    if (wb_read_data !== 32'hDEADBEEF || obs_rec !== rec) begin
      errors++; $display("FAIL load_rec got rd=%h rec=%h exp DEADBEEF %h", wb_read_data, obs_rec, rec);
    end
  endtask

  task automatic test_store_branch;
    logic [REC_W-1:0] rec; int lat, req;
    model(1, 0, 0, 1, 0, 0, 32'h20, 32'h0, 5'd4, 1, 0, rec, lat, req);
    issue(1, 0, 0, 1, 0, 0, 32'h20, 333, 32'h0, 5'd4, 1, 0);
    checks++;
    if (obs_we !== 1'b1 || obs_wdata !== 333 || obs_addr !== 32'h20 || obs_bus_bad) begin
      errors++; $display("FAIL store_bus got we=%b wdata=%0d addr=%h exp 1 333 20", obs_we, obs_wdata, obs_addr);
    end
    checks++;
    if (obs_timeout || wb_RegWrite !== 1'b0 || obs_rec !== rec) begin
      errors++; $display("FAIL store_rec got rw=%b rec=%h exp 0 %h", wb_RegWrite, obs_rec, rec);
    end
    model(0, 0, 0, 0, 1, 1, 32'h0, 111, 5'd0, -1, 0, rec, lat, req);
    issue(0, 0, 0, 0, 1, 1, 32'h0, 0, 111, 5'd0, -1, 0);
    checks++;
    if (PCSrc !== 1'b1 || branch_target !== 111 || obs_rec !== rec) begin
      errors++; $display("FAIL branch_taken got pcsrc=%b tgt=%0d exp 1 111", PCSrc, branch_target);
    end
    @(posedge clock); #1;
    checks++;
    if (PCSrc !== 1'b0) begin
      errors++; $display("FAIL branch_pulse got pcsrc=%b exp 0", PCSrc);
    end
    model(0, 0, 0, 0, 1, 0, 32'h1, 222, 5'd0, -1, 0, rec, lat, req);
    issue(0, 0, 0, 0, 1, 0, 32'h1, 0, 222, 5'd0, -1, 0);
    checks++;
    if (PCSrc !== 1'b0 || obs_rec !== rec) begin
      errors++; $display("FAIL branch_not_taken got pcsrc=%b exp 0", PCSrc);
    end
  endtask

  task automatic test_misaligned;
    logic [REC_W-1:0] rec; int lat, req;
    model(1, 1, 1, 0, 0, 0, 32'h102, 32'h0, 5'd11, 0, 32'h5555, rec, lat, req);
    issue(1, 1, 1, 0, 0, 0, 32'h102, 0, 32'h0, 5'd11, 0, 32'h5555);
    checks++;
    if (obs_req !== 0 || obs_lat !== 1) begin
      errors++; $display("FAIL misaligned_timing got req=%0d lat=%0d exp 0 1", obs_req, obs_lat);
    end
    checks++;
    if (misaligned !== 1'b1 || wb_RegWrite !== 1'b0 || obs_rec !== rec) begin
      errors++; $display("FAIL misaligned_rec got mis=%b rw=%b rec=%h exp 1 0 %h",
                         misaligned, wb_RegWrite, obs_rec, rec);
    end
  endtask

  task automatic test_timeout;
    logic [REC_W-1:0] rec; int lat, req;
    model(1, 1, 1, 0, 0, 0, 32'h200, 32'h0, 5'd12, -1, 0, rec, lat, req);
    issue(1, 1, 1, 0, 0, 0, 32'h200, 0, 32'h0, 5'd12, -1, 0);
    checks++;
    if (obs_req !== T || obs_lat !== T + 1) begin
      errors++; $display("FAIL timeout_timing got req=%0d lat=%0d exp %0d %0d", obs_req, obs_lat, T, T + 1);
    end
    checks++;
    if (bus_error !== 1'b1 || obs_rec !== rec) begin
      errors++; $display("FAIL timeout_rec got err=%b rec=%h exp 1 %h", bus_error, obs_rec, rec);
    end
    model(1, 1, 1, 0, 0, 0, 32'h204, 32'h0, 5'd13, T - 1, 32'hCAFE0001, rec, lat, req);
    issue(1, 1, 1, 0, 0, 0, 32'h204, 0, 32'h0, 5'd13, T - 1, 32'hCAFE0001);
    checks++;
    if (obs_req !== T || obs_lat !== T + 1 || bus_error !== 1'b0 || obs_rec !== rec) begin
      errors++; $display("FAIL late_ack got req=%0d lat=%0d err=%b rec=%h exp %0d %0d 0 %h",
                         obs_req, obs_lat, bus_error, obs_rec, T, T + 1, rec);
    end
  endtask

  task automatic test_stray_ack;
    logic [REC_W-1:0] rec; int lat, req;
    @(posedge clock); #1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
    @(posedge clock); #1;
    bus.mem_ack = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stray_ack got v=%b rdy=%b exp 0 1", wb_valid, in_ready);
    end
    model(1, 0, 0, 0, 0, 0, 32'h77, 32'h0, 5'd2, -1, 0, rec, lat, req);
    issue(1, 0, 0, 0, 0, 0, 32'h77, 0, 32'h0, 5'd2, -1, 0);
    checks++;
    if (obs_rec !== rec) begin
      errors++; $display("FAIL stray_ack_hold got %h exp %h", obs_rec, rec);
    end
  endtask

  task automatic test_random;
    logic [REC_W-1:0] rec, exp_rec;
    int lat, req, ack_k;
    logic rw, m2r, mr, mw, br, z;
    logic [DW-1:0] alu, rd2, add, rdata;
    logic [4:0] idx;
    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom); m2r = 1'($urandom); br = 1'($urandom); z = 1'($urandom);
      mr = ($urandom_range(0, 2) == 0); mw = ($urandom_range(0, 2) == 0);
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      rd2 = $urandom; add = $urandom; idx = 5'($urandom); rdata = $urandom;
      ack_k = $urandom_range(0, T + 1) - 1;
      model(rw, m2r, mr, mw, br, z, alu, add, idx, ack_k, rdata, rec, lat, req);
      exp_q.push_back(rec);
      issue(rw, m2r, mr, mw, br, z, alu, rd2, add, idx, ack_k, rdata);
      exp_rec = exp_q.pop_front();
      checks++;
      if (obs_timeout || obs_lat !== lat || obs_req !== req) begin
        errors++; $display("FAIL rand_timing[%0d] got lat=%0d req=%0d exp %0d %0d", i, obs_lat, obs_req, lat, req);
      end
      checks++;
      if (obs_rec !== exp_rec) begin
        errors++; $display("FAIL rand_rec[%0d] got %h exp %h", i, obs_rec, exp_rec);
      end
      if (req > 0) begin
        checks++;
        if (obs_addr !== alu || obs_we !== mw || (mw && obs_wdata !== rd2) || obs_bus_bad || obs_ready_bad) begin
          errors++; $display("FAIL rand_bus[%0d] got addr=%h we=%b wd=%h exp %h %b %h", i, obs_addr, obs_we, obs_wdata, alu, mw, rd2);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clock); #1;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0;
    RegWrite = 0; MemtoReg = 0; MemRead = 0; MemWrite = 0; Branch = 0; Zero = 0;
    ALU_result = '0; read_data_2 = '0; add_result = '0; write_register_index = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    mdl_rd = '0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    test_reset;
    test_rtype;
    test_back_to_back;
    test_load;
    test_store_branch;
    test_misaligned;
    test_timeout;
    test_stray_ack;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
